aes_inv_key_sched: RTL and testbench
====================================

// Module: aes_inv_key_sched
// PURPOSE
//  Sequential AES-128 inverse key schedule for the decryption datapath.
//  - Loads the round-10 key from the forward expansion.
//  - Walks backward one round per step (round 10 -> 0), regenerating each earlier
//    round key on the fly; all 44 words are never stored.
//  - Feeds the inverse-cipher round logic, which consumes keys in reverse order.
// PARAMETERS
//  REG_SBOX  0  1 = register SubWord output; each backward step then takes 2 cycles
// PORTS
//  clk       in   1    clock, rising edge
//  rst       in   1    asynchronous, active-high reset
//  start     in   1    load key_in and begin a sequence; accepted only when busy=0
//  key_in    in   128  round-10 key; word0 in [127:96] ... word3 in [31:0]
//  next      in   1    consumer has used rk_out; request the previous round key
//  rk_out    out  128  current round key, same word packing as key_in
//  rk_round  out  4    round index of rk_out (10..0)
//  rk_valid  out  1    rk_out/rk_round are valid
//  busy      out  1    sequence in progress
//  done      out  1    one-cycle pulse: round-0 key consumed, sequence finished
// BEHAVIOUR
//  - Reset (async, any time, including mid-sequence):
//    - state=IDLE; rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0.
//    - A sequence interrupted by reset is abandoned.
//  - States:
//    - IDLE: busy=0, rk_valid=0. start=1 -> rk_out<=key_in, rk_round<=10, go HOLD.
//      rk_valid=1 on the cycle after start.
//    - HOLD: busy=1, rk_valid=1.
//      - next=1 and rk_round>0:
//        - REG_SBOX=0: next edge rk_out<=prev key, rk_round-1; stay HOLD, rk_valid stays 1.
//          next held high yields one new key per cycle.
//        - REG_SBOX=1: go STEP (rk_valid=0 for exactly one cycle), then load prev key,
//          decrement rk_round, return to HOLD.
//      - next=1 and rk_round==0: go IDLE; rk_valid=0, busy=0; done=1 for one cycle.
//    - STEP (REG_SBOX=1 only): busy=1, rk_valid=0; next ignored.
//  - Backward step for round r (1..10), current words w0..w3 -> previous p0..p3:
//    - p3=w3^w2; p2=w2^w1; p1=w1^w0.
//    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon[r],24'h0}.
//    - RotWord(x) = {x[23:0],x[31:24]}.
//    - SubWord = standard AES forward S-box applied to each byte.
//    - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
//    - For REG_SBOX=1, the registered value is SubWord(RotWord(p3)), captured in the HOLD->STEP edge.
//  - rk_out and rk_round change only on load or step edges; stable throughout HOLD.
//  - start while busy=1 is ignored, including start and next in the same cycle.
//  - next while rk_valid=0 is ignored (no queuing).
//  - done and start in the same cycle cannot collide: done fires on the HOLD->IDLE edge;
//    a start in the following cycle is accepted.
//  - key_in is sampled only at the accepted start; later changes have no effect.
// TESTING
//  1 FIPS-197 key, round-10 key d014f9a8_c9ee2589_e13f0cc8_b6630ca6; start, then one next
//    -> rk_round=9, rk_out=ac7766f3_19fadc21_28d12941_575c006e.
//  2 Same key, next held high, REG_SBOX=0 -> 11 consecutive valid keys, rounds 10..0;
//    round 0 = 2b7e1516_28aed2a6_abf71588_09cf4f3c; one more next -> done=1 for 1 cycle,
//    then busy=0, rk_valid=0.
//  3 REG_SBOX=1, next held high -> rk_valid toggles 1,0,1,0...; final keys identical to test 2;
//    total 21 cycles from first next to done.
//  4 start pulsed with a different key_in during HOLD at round 7 -> ignored;
//    rk_round stays 7, rk_out unchanged.
//  5 Assert rst asynchronously at round 4 mid-sequence -> all outputs 0 immediately, without
//    waiting for a clock edge. New start then yields rk_round=10 with the new key_in.
//  6 Random keys (>=200): expand forward in the model, load the round-10 key, walk back
//    -> every rk_out matches the model round key; round 0 equals the original key.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: AES-128 inverse key schedule, one round key per backward step
// (round 10 -> 0), regenerating earlier keys on the fly. Rev 1.0.
`default_nettype none

module aes_inv_key_sched #(
  parameter int REG_SBOX = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         next_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_round_o,
  output logic         rk_valid_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STEP} state_t;

  state_t         state_q, state_d;
  logic [127:0]   rk_q;
  logic [3:0]     round_q;
  logic           done_q, done_d;
  logic           load, step;
  logic [31:0]    w_p0, w_p1, w_p2, w_p3;
  logic [31:0]    w_sub, w_sub_use;
  logic [7:0]     w_rcon;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  always_comb begin
    w_rcon = 8'h00;
    case (round_q)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Previous words 1..3 fall out of XORs; word 0 needs the S-box on RotWord(p3).
  assign w_p3  = rk_q[31:0]   ^ rk_q[63:32];
  assign w_p2  = rk_q[63:32]  ^ rk_q[95:64];
  assign w_p1  = rk_q[95:64]  ^ rk_q[127:96];
  assign w_sub = sub_word({w_p3[23:0], w_p3[31:24]});
  assign w_p0  = rk_q[127:96] ^ w_sub_use ^ {w_rcon, 24'h0};

  generate
    if (REG_SBOX != 0) begin : g_reg_sbox
      logic [31:0] sub_q;
      // rk_q is frozen through STEP, so the value captured in the last HOLD cycle stays valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                   sub_q <= '0;
        else if (state_q == S_HOLD) sub_q <= w_sub;
      end
      assign w_sub_use = sub_q;
    end else begin : g_comb_sbox
      assign w_sub_use = w_sub;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        load    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (next_i) begin
        if (round_q == 4'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (REG_SBOX != 0) begin
          state_d = S_STEP;
        end else begin
          step = 1'b1;
        end
      end
      S_STEP: begin
        step    = 1'b1;
        state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rk_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load) begin
        rk_q    <= key_i;
        round_q <= 4'd10;
      end else if (step) begin
        rk_q    <= {w_p0, w_p1, w_p2, w_p3};
        round_q <= round_q - 4'd1;
      end
    end
  end

  assign rk_o       = rk_q;
  assign rk_round_o = round_q;
  assign rk_valid_o = (state_q == S_HOLD);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: directed and random checks of both REG_SBOX variants
// against a forward-expansion reference model.
`default_nettype none

module tb_aes_inv_key_sched;

  localparam logic [127:0] KEY0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KEY9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
  localparam logic [127:0] KEY10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         s0 = 0, n0 = 0, s1 = 0, n1 = 0;
  logic [127:0] k0 = '0, k1 = '0;
  logic [127:0] rk0, rk1;
  logic [3:0]   rd0, rd1;
  logic         v0, b0, d0, v1, b1, d1;

  aes_inv_key_sched #(.REG_SBOX(0)) u_dut0 (
    .clk(clk), .rst(rst), .start_i(s0), .key_i(k0), .next_i(n0),
    .rk_o(rk0), .rk_round_o(rd0), .rk_valid_o(v0), .busy_o(b0), .done_o(d0));

  aes_inv_key_sched #(.REG_SBOX(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(s1), .key_i(k1), .next_i(n1),
    .rk_o(rk1), .rk_round_o(rd1), .rk_valid_o(v1), .busy_o(b1), .done_o(d1));

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_rk [0:10];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box derived from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] p = x;
    logic [7:0] r = 8'h01;
    logic [7:0] b;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    b = (x == 8'h00) ? 8'h00 : r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0]), sbox_m(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run0();
    k0 = exp_rk[10]; s0 = 1; tick(); s0 = 0;
    check("r0_load_round", rd0, 10);
    check("r0_load_key", rk0, exp_rk[10]);
    n0 = 1;
    for (int r = 9; r >= 0; r--) begin
      tick();
      check("r0_walk_round", rd0, r);
      check("r0_walk_key", rk0, exp_rk[r]);
    end
    tick(); n0 = 0;
    check("r0_done", {d0, b0, v0}, 3'b100);
  endtask

  task automatic run1();
    k1 = exp_rk[10]; s1 = 1; tick(); s1 = 0;
    check("r1_load_key", rk1, exp_rk[10]);
    n1 = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check("r1_valid", v1, (c % 2 == 0));
      if (c % 2 == 0) begin
        check("r1_round", rd1, 10 - c / 2);
        check("r1_key", rk1, exp_rk[10 - c / 2]);
      end
    end
    tick(); n1 = 0;
    check("r1_done_at_21", {d1, b1, v1}, 3'b100);
  endtask

  initial begin
    #1;
    check("reset_async", {rk0, rd0, v0, b0, d0}, '0);
    check("reset_async1", {rk1, rd1, v1, b1, d1}, '0);
    tick(); rst = 0;
    expand(KEY0);
    check("model_round10", exp_rk[10], KEY10);

    // One backward step from the FIPS-197 round-10 key
    k0 = KEY10; s0 = 1; tick(); s0 = 0;
    check("t1_load", {b0, v0, rd0}, {2'b11, 4'd10});
    check("t1_key10", rk0, KEY10);
    n0 = 1; tick(); n0 = 0;
    check("t1_round9", rd0, 9);
    check("t1_key9", rk0, KEY9);
    tick();
    check("t1_hold_stable", {v0, rd0, rk0}, {1'b1, 4'd9, KEY9});

    // next held through round 0, then done; start accepted in the done cycle
    n0 = 1;
    for (int r = 8; r >= 0; r--) begin
      tick();
      check("t2_round", {v0, rd0}, {1'b1, 4'(r)});
      check("t2_key", rk0, exp_rk[r]);
    end
    check("t2_key0_hand", rk0, KEY0);
    tick(); n0 = 0;
    check("t2_done", {d0, b0, v0}, 3'b100);
    s0 = 1; k0 = KEY10; tick(); s0 = 0;
    check("t2_done_low", d0, 0);
    check("t2_restart", {v0, rd0, rk0}, {1'b1, 4'd10, KEY10});

    // Start while busy is ignored, also together with next
    for (int i = 0; i < 3; i++) begin
      n0 = 1; tick(); n0 = 0;
    end
    check("t4_round7", rd0, 7);
    s0 = 1; k0 = ~KEY10; tick(); s0 = 0;
    check("t4_ign_round", rd0, 7);
    check("t4_ign_key", rk0, exp_rk[7]);
    s0 = 1; n0 = 1; tick(); s0 = 0; n0 = 0;
    check("t4_start_next", {rd0, rk0}, {4'd6, exp_rk[6]});
    n0 = 1; tick(); tick(); n0 = 0;
    check("t4_round4", rd0, 4);

    // Asynchronous reset mid-sequence
    #3 rst = 1;
    #1;
    check("t5_async_rst", {rk0, rd0, v0, b0, d0}, '0);
    tick(); rst = 0;
    expand({$urandom, $urandom, $urandom, $urandom});
    k0 = exp_rk[10]; s0 = 1; tick(); s0 = 0;
    check("t5_restart", {v0, rd0, rk0}, {1'b1, 4'd10, exp_rk[10]});
    n0 = 1;
    repeat (11) tick();
    n0 = 0;
    check("t5_finish", {b0, v0}, 2'b00);

    // Registered S-box variant: valid toggles, done 21 cycles after first next
    expand(KEY0);
    run1();
    check("t3_key0_hand", exp_rk[0], KEY0);

    for (int i = 0; i < 200; i++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      run0();
      if (i < 20) run1();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
